// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
//
// Data memory for the MEM stage of an RV32IM pipeline. Byte-addressed,
// little-endian storage organised as DEPTH_WORDS 32-bit words. Every access
// takes LATENCY clock edges from request capture to completion, and the
// pipeline is held off with busywait while the access is outstanding.
//
// Access life cycle:
//   IDLE : a valid request is visible combinationally on busywait; the
//          rising edge captures address, type, store data and direction.
//   BUSY : busywait held high while the latency counter runs down; the edge
//          that sees the counter at zero performs the access.
//   DONE : busywait low for exactly one cycle and the debug strobe for the
//          completed access is high. Inputs are ignored here, so an enable
//          that is still held does not launch a second access.
//
// Ports:
//   clock           in   1   rising-edge clock for all state
//   reset           in   1   synchronous, active-low reset
//   read            in   4   {en, type[2:0]}: 000 LW, 001 LH, 010 LHU,
//                            011 LB, 100 LBU; 101-111 mean no access
//   write           in   3   {en, type[1:0]}: 00 SW, 01 SH, 10 SB;
//                            11 means no access
//   address         in   32  byte address; word index wraps modulo DEPTH_WORDS
//   writedata       in   32  store data; low half/byte used for SH/SB
//   readdata        out  32  extended load result; holds until the next load
//   busywait        out  1   high while a request is pending or in progress
//   DEBUG_DATA      out  32  load result or stored data of the last access
//   DEBUG_READ_ACC  out  1   high during the DONE cycle of a load
//   DEBUG_WRITE_ACC out  1   high during the DONE cycle of a store
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two)
//   LATENCY      edges from request capture to completion (>= 1)
// ---------------------------------------------------------------------------
module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  read,
    input  logic [2:0]  write,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait,
    output logic [31:0] DEBUG_DATA,
    output logic        DEBUG_READ_ACC,
    output logic        DEBUG_WRITE_ACC
);

    // Word index width; the index is taken straight from the address bits
    // above the byte offset, so truncation gives the modulo-depth wrap.
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // The counter only ever holds values 0 .. LATENCY-1.
    localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_H  = 3'b001,
        LD_HU = 3'b010,
        LD_B  = 3'b011,
        LD_BU = 3'b100
    } load_type_t;

    typedef enum logic [1:0] {
        ST_W = 2'b00,
        ST_H = 2'b01,
        ST_B = 2'b10
    } store_type_t;

    // -----------------------------------------------------------------------
    // Storage and control state
    // -----------------------------------------------------------------------
    logic [31:0]      mem [DEPTH_WORDS];

    state_t           state;
    logic [CNT_W-1:0] count;

    // Request captured at the IDLE edge; the requester may drop everything
    // after that edge.
    logic [IDX_W-1:0] acc_idx;
    logic [1:0]       acc_off;
    logic             acc_is_store;
    load_type_t       acc_ld_type;
    store_type_t      acc_st_type;
    logic [31:0]      acc_wdata;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic rd_valid;
    logic wr_valid;
    logic request;

    assign rd_valid = read[3]  && (read[2:0] <= 3'b100);
    assign wr_valid = write[2] && (write[1:0] != 2'b11);
    assign request  = rd_valid || wr_valid;

    // Address bits above the word index do not select anything; the memory
    // simply aliases across them.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[31:IDX_W+2];

    // -----------------------------------------------------------------------
    // Access datapath, working from the captured request
    // -----------------------------------------------------------------------
    logic [31:0] cur_word;
    logic [15:0] load_half;
    logic [7:0]  load_byte;
    logic [31:0] load_value;
    logic [3:0]  lane_en;
    logic [31:0] lane_data;
    logic [31:0] store_value;
    logic [31:0] merged_word;

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cur_word    = mem[acc_idx];
        load_half   = '0;
        load_byte   = '0;
        load_value  = '0;
        lane_en     = '0;
        lane_data   = '0;
        store_value = '0;
        merged_word = cur_word;

        // Halfword selection uses address[1] only; address[0] is ignored so
        // misaligned halves are silently aligned.
        load_half = acc_off[1] ? cur_word[31:16] : cur_word[15:0];
        load_byte = cur_word[{acc_off, 3'b000} +: 8];

        case (acc_ld_type)
            LD_W:    load_value = cur_word;
            LD_H:    load_value = {{16{load_half[15]}}, load_half};
            LD_HU:   load_value = {16'h0000, load_half};
            LD_B:    load_value = {{24{load_byte[7]}}, load_byte};
            LD_BU:   load_value = {24'h000000, load_byte};
            default: load_value = cur_word;
        endcase

        // Stores replicate the source across the word and enable only the
        // addressed lanes, so untouched bytes keep their old contents.
        case (acc_st_type)
            ST_W: begin
                lane_en     = 4'b1111;
                lane_data   = acc_wdata;
                store_value = acc_wdata;
            end
            ST_H: begin
                lane_en     = acc_off[1] ? 4'b1100 : 4'b0011;
                lane_data   = {2{acc_wdata[15:0]}};
                store_value = {16'h0000, acc_wdata[15:0]};
            end
            ST_B: begin
                lane_en     = 4'b0001 << acc_off;
                lane_data   = {4{acc_wdata[7:0]}};
                store_value = {24'h000000, acc_wdata[7:0]};
            end
            default: begin
                lane_en     = 4'b0000;
                lane_data   = '0;
                store_value = '0;
            end
        endcase

        for (int n = 0; n < 4; n++) begin
            merged_word[8*n +: 8] = lane_en[n] ? lane_data[8*n +: 8]
                                               : cur_word[8*n +: 8];
        end
    end

    // Completion happens on the BUSY edge that finds the counter at zero.
    logic complete;
    logic store_fire;

    assign complete   = (state == BUSY) && (count == '0);
    assign store_fire = complete && acc_is_store;

    // -----------------------------------------------------------------------
    // busywait: combinational in IDLE so the pipeline stalls in the same
    // cycle the request appears; forced low in DONE so the stage advances.
    // -----------------------------------------------------------------------
    always_comb begin
        busywait = 1'b0;
        case (state)
            IDLE:    busywait = request;
            BUSY:    busywait = 1'b1;
            DONE:    busywait = 1'b0;
            default: busywait = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Memory array
    // -----------------------------------------------------------------------
    // NOTE: reset here clears every word, which costs a flop-based array
    // rather than a RAM macro; this is intentional so software can rely on
    // zeroed data memory after reset. Reset wins over a completing store.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (store_fire) begin
            mem[acc_idx] <= merged_word;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
    // NOTE: all state in clocked blocks uses non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            count           <= '0;
            acc_idx         <= '0;
            acc_off         <= '0;
            acc_is_store    <= 1'b0;
            acc_ld_type     <= LD_W;
            acc_st_type     <= ST_W;
            acc_wdata       <= '0;
            readdata        <= '0;
            DEBUG_DATA      <= '0;
            DEBUG_READ_ACC  <= 1'b0;
            DEBUG_WRITE_ACC <= 1'b0;
        end else begin
            // Strobes live for the DONE cycle only.
            DEBUG_READ_ACC  <= 1'b0;
            DEBUG_WRITE_ACC <= 1'b0;

            case (state)
                IDLE: begin
                    if (request) begin
                        acc_idx      <= address[IDX_W+1:2];
                        acc_off      <= address[1:0];
                        // A store wins when both enables are valid; the
                        // load is dropped entirely.
                        acc_is_store <= wr_valid;
                        acc_ld_type  <= load_type_t'(read[2:0]);
                        acc_st_type  <= store_type_t'(write[1:0]);
                        acc_wdata    <= writedata;
                        count        <= CNT_LOAD;
                        state        <= BUSY;
                    end
                end

                BUSY: begin
                    if (complete) begin
                        if (acc_is_store) begin
                            DEBUG_DATA      <= store_value;
                            DEBUG_WRITE_ACC <= 1'b1;
                        end else begin
                            readdata        <= load_value;
                            DEBUG_DATA      <= load_value;
                            DEBUG_READ_ACC  <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                DONE: begin
                    // Held enables are ignored here; a new request can only
                    // be captured once back in IDLE.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// ---------------------------------------------------------------------------
// tb_data_memory
//
// Self-checking bench for data_memory. A byte-array model of the memory
// (plain byte-addressed arithmetic, little-endian) supplies every expected
// value; directed scenarios use literal values worked out by hand.
// ---------------------------------------------------------------------------
module tb_data_memory;

    localparam int LATENCY     = 3;
    localparam int DEPTH_WORDS = 256;
    localparam int MEM_BYTES   = DEPTH_WORDS * 4;
    localparam int MAX_WAIT    = 50;

    localparam logic [2:0] T_LW  = 3'b000;
    localparam logic [2:0] T_LH  = 3'b001;
    localparam logic [2:0] T_LHU = 3'b010;
    localparam logic [2:0] T_LB  = 3'b011;
    localparam logic [2:0] T_LBU = 3'b100;
    localparam logic [1:0] T_SW  = 2'b00;
    localparam logic [1:0] T_SH  = 2'b01;
    localparam logic [1:0] T_SB  = 2'b10;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  read = '0;
    logic [2:0]  write = '0;
    logic [31:0] address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        busywait;
    logic [31:0] DEBUG_DATA;
    logic        DEBUG_READ_ACC;
    logic        DEBUG_WRITE_ACC;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]  model_bytes [MEM_BYTES];
    logic [31:0] last_load;

    data_memory #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .LATENCY    (LATENCY)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .read           (read),
        .write          (write),
        .address        (address),
        .writedata      (writedata),
        .readdata       (readdata),
        .busywait       (busywait),
        .DEBUG_DATA     (DEBUG_DATA),
        .DEBUG_READ_ACC (DEBUG_READ_ACC),
        .DEBUG_WRITE_ACC(DEBUG_WRITE_ACC)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Reference model: flat byte array, address taken modulo its size
    // -----------------------------------------------------------------------
    task automatic model_clear();
        for (int i = 0; i < MEM_BYTES; i++) model_bytes[i] = 8'h00;
    endtask

    function automatic int byte_pos(input logic [31:0] a);
        return int'(a % MEM_BYTES);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a);
        int          p;
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        r = '0;
        if (t == T_LW) begin
            p = byte_pos(a) - (byte_pos(a) % 4);
            r = {model_bytes[p+3], model_bytes[p+2], model_bytes[p+1], model_bytes[p]};
        end else if (t == T_LH || t == T_LHU) begin
            p = byte_pos(a) - (byte_pos(a) % 2);
            h = {model_bytes[p+1], model_bytes[p]};
            r = (t == T_LH) ? {{16{h[15]}}, h} : {16'h0000, h};
        end else begin
            b = model_bytes[byte_pos(a)];
            r = (t == T_LB) ? {{24{b[7]}}, b} : {24'h000000, b};
        end
        return r;
    endfunction

    // Applies a store to the model and returns what the debug port reports.
    task automatic model_store(input logic [1:0] t, input logic [31:0] a,
                               input logic [31:0] d, output logic [31:0] dbg);
        int p;
        if (t == T_SW) begin
            p = byte_pos(a) - (byte_pos(a) % 4);
            for (int k = 0; k < 4; k++) model_bytes[p+k] = 8'((d >> (8*k)) & 32'hFF);
            dbg = d;
        end else if (t == T_SH) begin
            p = byte_pos(a) - (byte_pos(a) % 2);
            model_bytes[p]   = 8'(d & 32'hFF);
            model_bytes[p+1] = 8'((d >> 8) & 32'hFF);
            dbg = d & 32'h0000_FFFF;
        end else begin
            model_bytes[byte_pos(a)] = 8'(d & 32'hFF);
            dbg = d & 32'h0000_00FF;
        end
    endtask

    // -----------------------------------------------------------------------
    // One complete access, starting and ending in IDLE (sampled 1ns after
    // the rising edge). Returns what was seen in the DONE cycle.
    // -----------------------------------------------------------------------
    task automatic do_access(input logic [3:0] rd, input logic [2:0] wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input string name,
                             output logic [31:0] rdata, output logic [31:0] dbg,
                             output logic rd_pulse, output logic wr_pulse);
        int n;
        read = rd; write = wr; address = addr; writedata = wdata;
        #1;
        tests_run++;
        if (busywait !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s request_busywait: got %b expected 1", name, busywait);
        end
        @(posedge clock); #1;
        // Scramble the bus after capture; the DUT must work from its copy.
        read = '0; write = '0; address = $urandom; writedata = $urandom;
        n = 0;
        while (busywait === 1'b1 && n < MAX_WAIT) begin
            n++;
            @(posedge clock); #1;
        end
        tests_run++;
        if (n != LATENCY) begin
            tests_failed++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, LATENCY);
        end
        rdata    = readdata;
        dbg      = DEBUG_DATA;
        rd_pulse = DEBUG_READ_ACC;
        wr_pulse = DEBUG_WRITE_ACC;
        @(posedge clock); #1;
        tests_run++;
        if ({DEBUG_READ_ACC, DEBUG_WRITE_ACC} !== 2'b00) begin
            tests_failed++;
            $display("FAIL %s strobe_after_done: got %b expected 00", name,
                     {DEBUG_READ_ACC, DEBUG_WRITE_ACC});
        end
    endtask

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] r, d;
        logic        rp, wp;
        read = '0; write = '0; address = '0; writedata = '0;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        model_clear();
        tests_run++;
        if ({busywait, DEBUG_READ_ACC, DEBUG_WRITE_ACC} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 000",
                     {busywait, DEBUG_READ_ACC, DEBUG_WRITE_ACC});
        end
        tests_run++;
        if (readdata !== 32'h0 || DEBUG_DATA !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got readdata=%h debug=%h expected 0", readdata, DEBUG_DATA);
        end
        do_access({1'b1, T_LW}, 3'b000, 32'h0, 32'h0, "reset_lw0", r, d, rp, wp);
        tests_run++;
        if (r !== 32'h0 || rp !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_lw0: got %h pulse=%b expected 00000000 pulse=1", r, rp);
        end
        last_load = 32'h0;
    endtask

    task automatic test_store_then_load();
        logic [31:0] r, d, md;
        logic        rp, wp;
        do_access(4'b0000, {1'b1, T_SW}, 32'h04, 32'hAABBCCDD, "sw_04", r, d, rp, wp);
        model_store(T_SW, 32'h04, 32'hAABBCCDD, md);
        tests_run++;
        if (wp !== 1'b1 || rp !== 1'b0 || d !== 32'hAABBCCDD) begin
            tests_failed++;
            $display("FAIL sw_04: got wr=%b rd=%b debug=%h expected 1 0 aabbccdd", wp, rp, d);
        end
        do_access({1'b1, T_LW}, 3'b000, 32'h04, 32'h0, "lw_04", r, d, rp, wp);
        tests_run++;
        if (r !== 32'hAABBCCDD || rp !== 1'b1 || wp !== 1'b0 || d !== 32'hAABBCCDD) begin
            tests_failed++;
            $display("FAIL lw_04: got %h rd=%b wr=%b debug=%h expected aabbccdd 1 0", r, rp, wp, d);
        end
        last_load = 32'hAABBCCDD;
    endtask

    task automatic test_lanes();
        logic [31:0] r, d, md;
        logic        rp, wp;
        logic [31:0] exp_tab [5];
        logic [3:0]  rd_tab  [5];
        logic [31:0] adr_tab [5];
        do_access(4'b0000, {1'b1, T_SW}, 32'h08, 32'h11223344, "sw_08", r, d, rp, wp);
        model_store(T_SW, 32'h08, 32'h11223344, md);
        rd_tab[0] = {1'b1, T_LB};  adr_tab[0] = 32'h0B; exp_tab[0] = 32'h00000011;
        rd_tab[1] = {1'b1, T_LBU}; adr_tab[1] = 32'h08; exp_tab[1] = 32'h00000044;
        rd_tab[2] = {1'b1, T_LH};  adr_tab[2] = 32'h0A; exp_tab[2] = 32'h00001122;
        rd_tab[3] = {1'b1, T_LW};  adr_tab[3] = 32'h08; exp_tab[3] = 32'h1122FF44;
        rd_tab[4] = {1'b1, T_LB};  adr_tab[4] = 32'h09; exp_tab[4] = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                do_access(4'b0000, {1'b1, T_SB}, 32'h09, 32'h000000FF, "sb_09", r, d, rp, wp);
                model_store(T_SB, 32'h09, 32'h000000FF, md);
                tests_run++;
                if (d !== 32'h000000FF || wp !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL sb_09: got debug=%h wr=%b expected 000000ff 1", d, wp);
                end
            end
            do_access(rd_tab[i], 3'b000, adr_tab[i], 32'h0, "lane_load", r, d, rp, wp);
            tests_run++;
            if (r !== exp_tab[i]) begin
                tests_failed++;
                $display("FAIL lane_load_%0d: got %h expected %h", i, r, exp_tab[i]);
            end
            last_load = exp_tab[i];
        end
    endtask

    task automatic test_invalid_types();
        logic [31:0] r, d;
        logic        rp, wp;
        int          strobes;
        read = 4'b1101; write = 3'b111; address = 32'h08; writedata = 32'h0;
        #1;
        tests_run++;
        if (busywait !== 1'b0) begin
            tests_failed++;
            $display("FAIL invalid_busywait: got %b expected 0", busywait);
        end
        strobes = 0;
        for (int i = 0; i < LATENCY + 2; i++) begin
            @(posedge clock); #1;
            if (busywait !== 1'b0 || DEBUG_READ_ACC !== 1'b0 || DEBUG_WRITE_ACC !== 1'b0) strobes++;
        end
        read = '0; write = '0;
        tests_run++;
        if (strobes != 0) begin
            tests_failed++;
            $display("FAIL invalid_no_access: got %0d active cycles expected 0", strobes);
        end
        do_access({1'b1, T_LW}, 3'b000, 32'h08, 32'h0, "invalid_after", r, d, rp, wp);
        tests_run++;
        if (r !== model_load(T_LW, 32'h08)) begin
            tests_failed++;
            $display("FAIL invalid_after: got %h expected %h", r, model_load(T_LW, 32'h08));
        end
        last_load = model_load(T_LW, 32'h08);
    endtask

    task automatic test_hold_enable();
        int n;
        read = {1'b1, T_LW}; write = '0; address = 32'h04;
        #1;
        @(posedge clock); #1;
        n = 0;
        while (busywait === 1'b1 && n < MAX_WAIT) begin
            n++;
            @(posedge clock); #1;
        end
        tests_run++;
        if (n != LATENCY || DEBUG_READ_ACC !== 1'b1 || readdata !== 32'hAABBCCDD) begin
            tests_failed++;
            $display("FAIL hold_first: got cycles=%0d pulse=%b data=%h expected %0d 1 aabbccdd",
                     n, DEBUG_READ_ACC, readdata, LATENCY);
        end
        // DONE with the enable still held: must not stall.
        tests_run++;
        if (busywait !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_done_busywait: got %b expected 0", busywait);
        end
        @(posedge clock); #1;
        // Back in IDLE: the held enable is a fresh request.
        tests_run++;
        if (busywait !== 1'b1 || DEBUG_READ_ACC !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_idle: got busy=%b pulse=%b expected 1 0", busywait, DEBUG_READ_ACC);
        end
        @(posedge clock); #1;
        read = '0;
        n = 0;
        while (busywait === 1'b1 && n < MAX_WAIT) begin
            n++;
            @(posedge clock); #1;
        end
        tests_run++;
        if (n != LATENCY || DEBUG_READ_ACC !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_second: got cycles=%0d pulse=%b expected %0d 1", n, DEBUG_READ_ACC, LATENCY);
        end
        @(posedge clock); #1;
        last_load = 32'hAABBCCDD;
    endtask

    task automatic test_simultaneous();
        logic [31:0] r, d, md;
        logic        rp, wp;
        do_access({1'b1, T_LW}, {1'b1, T_SW}, 32'h10, 32'h5A5A5A5A, "both_en", r, d, rp, wp);
        model_store(T_SW, 32'h10, 32'h5A5A5A5A, md);
        tests_run++;
        if (wp !== 1'b1 || rp !== 1'b0 || r !== last_load || d !== 32'h5A5A5A5A) begin
            tests_failed++;
            $display("FAIL both_en: got wr=%b rd=%b readdata=%h debug=%h expected 1 0 %h 5a5a5a5a",
                     wp, rp, r, d, last_load);
        end
        do_access({1'b1, T_LW}, 3'b000, 32'h10, 32'h0, "both_en_lw", r, d, rp, wp);
        tests_run++;
        if (r !== 32'h5A5A5A5A) begin
            tests_failed++;
            $display("FAIL both_en_lw: got %h expected 5a5a5a5a", r);
        end
        last_load = 32'h5A5A5A5A;
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] r, d;
        logic        rp, wp;
        write = {1'b1, T_SW}; read = '0; address = 32'h0C; writedata = 32'hDEADBEEF;
        #1;
        @(posedge clock); #1;
        write = '0;
        // Advance to the last BUSY cycle so reset lands on the completion edge.
        repeat (LATENCY - 1) @(posedge clock);
        #1;
        tests_run++;
        if (busywait !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_busy: got %b expected 1", busywait);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        model_clear();
        tests_run++;
        if (busywait !== 1'b0 || DEBUG_WRITE_ACC !== 1'b0 || DEBUG_DATA !== 32'h0 || readdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL midreset_state: got busy=%b wr=%b debug=%h readdata=%h expected 0 0 0 0",
                     busywait, DEBUG_WRITE_ACC, DEBUG_DATA, readdata);
        end
        @(posedge clock); #1;
        tests_run++;
        if (busywait !== 1'b0 || DEBUG_WRITE_ACC !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_after: got busy=%b wr=%b expected 0 0", busywait, DEBUG_WRITE_ACC);
        end
        do_access({1'b1, T_LW}, 3'b000, 32'h0C, 32'h0, "midreset_lw", r, d, rp, wp);
        tests_run++;
        if (r !== 32'h0) begin
            tests_failed++;
            $display("FAIL midreset_lw: got %h expected 00000000", r);
        end
        last_load = 32'h0;
    endtask

    // Random back-to-back traffic: each access starts in the IDLE cycle that
    // immediately follows the previous DONE.
    task automatic test_back_to_back_random();
        logic [31:0] r, d, addr, data, exp, md;
        logic        rp, wp;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic [3:0]  rd;
        for (int i = 0; i < 300; i++) begin
            addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
            data = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                st = 2'($urandom_range(0, 2));
                rd = ($urandom_range(0, 3) == 0) ? {1'b1, 3'($urandom_range(0, 4))} : 4'b0000;
                do_access(rd, {1'b1, st}, addr, data, "rand_store", r, d, rp, wp);
                model_store(st, addr, data, md);
                tests_run++;
                if (wp !== 1'b1 || rp !== 1'b0 || d !== md || r !== last_load) begin
                    tests_failed++;
                    $display("FAIL rand_store[%0d]: got wr=%b rd=%b debug=%h readdata=%h expected 1 0 %h %h (type %0d addr %h)",
                             i, wp, rp, d, r, md, last_load, st, addr);
                end
            end else begin
                lt  = 3'($urandom_range(0, 4));
                exp = model_load(lt, addr);
                do_access({1'b1, lt}, 3'b000, addr, data, "rand_load", r, d, rp, wp);
                tests_run++;
                if (rp !== 1'b1 || wp !== 1'b0 || r !== exp || d !== exp) begin
                    tests_failed++;
                    $display("FAIL rand_load[%0d]: got rd=%b wr=%b readdata=%h debug=%h expected 1 0 %h (type %0d addr %h)",
                             i, rp, wp, r, d, exp, lt, addr);
                end
                last_load = exp;
            end
        end
    endtask

    initial begin
        last_load = '0;
        test_reset();
        test_store_then_load();
        test_lanes();
        test_invalid_types();
        test_hold_enable();
        test_simultaneous();
        test_reset_mid_access();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
